// File: rtl/console_frame_arbiter_if.sv
// Handshake bundle between the n64_controller bank, serial_handler and the frame arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface console_frame_arbiter_if #(
  parameter int NUM_CONSOLES = 4
);
  logic [NUM_CONSOLES-1:0] console_ready;
  logic                    frame_written;
  logic                    clear_overrides;
  logic                    request_frame;
  logic [NUM_CONSOLES-1:0] ignored_mask;
  logic                    timeout_pulse;
  logic [1:0]              state_dbg;

  modport slave (
    input  console_ready,
    input  frame_written,
    input  clear_overrides,
    output request_frame,
    output ignored_mask,
    output timeout_pulse,
    output state_dbg
  );

  modport master (
    output console_ready,
    output frame_written,
    output clear_overrides,
    input  request_frame,
    input  ignored_mask,
    input  timeout_pulse,
    input  state_dbg
  );
endinterface

// File: rtl/console_frame_arbiter.sv
// Raises one frame request when every non-ignored console is ready.
// Consoles that stall the bank past TIMEOUT_CYCLES are ignored until cleared.
module console_frame_arbiter #(
  parameter int          NUM_CONSOLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  console_frame_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    REQUEST = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [31:0]             count_q, count_d;
  logic [NUM_CONSOLES-1:0] mask_q, mask_d;
  logic                    request_q, request_d;
  logic                    pulse_q, pulse_d;

  logic [NUM_CONSOLES-1:0] timeout_bits;
  logic                    timeout_fire;
  logic                    all_ready;
  logic                    any_live;

  assign all_ready = &(bus.console_ready | mask_q);
  assign any_live  = |(bus.console_ready & ~mask_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mask_q    <= '0;
      request_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
      request_q <= request_d;
      pulse_q   <= pulse_d;
    end
  end

  // An unsolicited frame_written outranks every IDLE/WAIT decision.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    timeout_bits = '0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_written) begin
          state_d = IDLE;
          count_d = '0;
        end else if (all_ready && any_live) begin
          state_d = REQUEST;
        end else if (any_live) begin
          state_d = WAIT;
          count_d = '0;
        end
      end
      WAIT: begin
        if (bus.frame_written) begin
          state_d = IDLE;
          count_d = '0;
        end else if (all_ready) begin
          state_d = REQUEST;
        end else if (!any_live) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d      = REQUEST;
          timeout_bits = ~bus.console_ready;
          timeout_fire = 1'b1;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      REQUEST: begin
        if (bus.frame_written) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    mask_d    = (bus.clear_overrides ? '0 : mask_q) | timeout_bits;
    request_d = (state_d == REQUEST);
    pulse_d   = timeout_fire;
  end

  assign bus.request_frame = request_q;
  assign bus.ignored_mask  = mask_q;
  assign bus.timeout_pulse = pulse_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_console_frame_arbiter.sv
// Directed bench for console_frame_arbiter with NUM_CONSOLES=4, TIMEOUT_CYCLES=100.
// A vector table covers single-cycle behaviour; hand sequences cover timeout and reset corners.
module tb_console_frame_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  console_frame_arbiter_if #(.NUM_CONSOLES(4)) bus ();

  console_frame_arbiter #(
    .NUM_CONSOLES  (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [3:0] ready;
    logic       fw;
    logic       clr;
    logic       exp_req;
    logic [1:0] exp_state;
    logic [3:0] exp_mask;
    logic       exp_pulse;
  } vec_t;

  vec_t vecs [13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] ready, input logic fw, input logic clr);
    bus.console_ready   = ready;
    bus.frame_written   = fw;
    bus.clear_overrides = clr;
    @(posedge clk);
    #1;
    bus.frame_written   = 1'b0;
    bus.clear_overrides = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic exp_req, input logic [1:0] exp_state,
                             input logic [3:0] exp_mask, input logic exp_pulse);
    checks++;
    if (bus.request_frame !== exp_req) begin
      failures++;
      $display("[TB] FAIL %s request_frame got %b expected %b", tag, bus.request_frame, exp_req);
    end
    checks++;
    if (bus.state_dbg !== exp_state) begin
      failures++;
      $display("[TB] FAIL %s state_dbg got %0d expected %0d", tag, bus.state_dbg, exp_state);
    end
    checks++;
    if (bus.ignored_mask !== exp_mask) begin
      failures++;
      $display("[TB] FAIL %s ignored_mask got %b expected %b", tag, bus.ignored_mask, exp_mask);
    end
    checks++;
    if (bus.timeout_pulse !== exp_pulse) begin
      failures++;
      $display("[TB] FAIL %s timeout_pulse got %b expected %b", tag, bus.timeout_pulse, exp_pulse);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.console_ready   = 4'b0000;
    bus.frame_written   = 1'b0;
    bus.clear_overrides = 1'b0;
    rst = 1'b1;

    // ready, fw, clr, exp_req, exp_state, exp_mask, exp_pulse
    vecs[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0};
    vecs[7]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[10] = '{4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[11] = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ready, vecs[i].fw, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_state,
                  vecs[i].exp_mask, vecs[i].exp_pulse);
    end

    $display("[TB] staggered ready bits");
    for (int s = 0; s < 22; s++) begin
      logic [3:0] r;
      r = {(s >= 20), (s >= 10), (s >= 5), 1'b1};
      applyStimulus(r, 1'b0, 1'b0);
      if (s < 20) checkOutput($sformatf("stagger%0d", s), 1'b0, 2'd1, 4'b0000, 1'b0);
      else        checkOutput($sformatf("stagger%0d", s), 1'b1, 2'd2, 4'b0000, 1'b0);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("stagger_done", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("[TB] timeout on console 3");
    for (int s = 0; s < 100; s++) begin
      applyStimulus(4'b0111, 1'b0, 1'b0);
      checkOutput($sformatf("to_wait%0d", s), 1'b0, 2'd1, 4'b0000, 1'b0);
    end
    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("to_fire", 1'b1, 2'd2, 4'b1000, 1'b1);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("to_pulse_once", 1'b1, 2'd2, 4'b1000, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("to_written", 1'b0, 2'd0, 4'b1000, 1'b0);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("to_next_round", 1'b1, 2'd2, 4'b1000, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("to_round_done", 1'b0, 2'd0, 4'b1000, 1'b0);

    $display("[TB] all_ready beats timeout");
    for (int s = 0; s < 100; s++) begin
      applyStimulus(4'b0011, 1'b0, 1'b0);
      checkOutput($sformatf("race_wait%0d", s), 1'b0, 2'd1, 4'b1000, 1'b0);
    end
    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("race_all_ready", 1'b1, 2'd2, 4'b1000, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("race_done", 1'b0, 2'd0, 4'b1000, 1'b0);

    $display("[TB] clear_overrides with timeout");
    for (int s = 0; s < 100; s++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkOutput($sformatf("clr_wait%0d", s), 1'b0, 2'd1, 4'b1000, 1'b0);
    end
    applyStimulus(4'b0001, 1'b0, 1'b1);
    checkOutput("clr_same_cycle", 1'b1, 2'd2, 4'b1110, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("clr_in_request", 1'b1, 2'd2, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("clr_written", 1'b0, 2'd0, 4'b0000, 1'b0);
    for (int s = 0; s < 100; s++) applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("clr_refire", 1'b1, 2'd2, 4'b1110, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("clr_idle_masked", 1'b0, 2'd0, 4'b1110, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("clr_idle_hold", 1'b0, 2'd0, 4'b1110, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("clr_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("clr_idle_after", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("[TB] asynchronous reset during request");
    for (int s = 0; s < 100; s++) begin
      applyStimulus(4'b1011, 1'b0, 1'b0);
      checkOutput($sformatf("rst_wait%0d", s), 1'b0, 2'd1, 4'b0000, 1'b0);
    end
    applyStimulus(4'b1011, 1'b0, 1'b0);
    checkOutput("rst_pre", 1'b1, 2'd2, 4'b0100, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 1'b0, 2'd0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("rst_recover", 1'b1, 2'd2, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
